t09_collision_scan: RTL and testbench

T09_COLLISION_SCAN -- requirements
Module: t09_collision_scan

---
 rtl/t09_pkg.sv | 14 +
 rtl/t09_collision_scan_if.sv | 27 ++
 rtl/t09_collision_scan.sv | 187 ++++++++++++++++++
 tb/tb_t09_collision_scan.sv | 300 ++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/t09_pkg.sv
// Shared types and playfield defaults for the collision scanner.
package t09_pkg;

  localparam int unsigned GridWDefault = 32;
  localparam int unsigned GridHDefault = 24;

  typedef enum logic [1:0] {
    IDLE,
    CHECK,
    SCAN,
    FINISH
  } state_e;

endpackage

// File: rtl/t09_collision_scan_if.sv
// Body-segment memory read port: scanner issues index, memory returns cell one cycle later.
interface t09_collision_scan_if #(
  parameter int unsigned IDX_W = 6,
  parameter int unsigned X_W   = 5,
  parameter int unsigned Y_W   = 5
);

  logic             body_rd_en;
  logic [IDX_W-1:0] body_rd_idx;
  logic [X_W-1:0]   body_x;
  logic [Y_W-1:0]   body_y;

  modport master (
    output body_rd_en,
    output body_rd_idx,
    input  body_x,
    input  body_y
  );

  modport slave (
    input  body_rd_en,
    input  body_rd_idx,
    output body_x,
    output body_y
  );

endinterface

// File: rtl/t09_collision_scan.sv
// Snake head collision checker: wall test, then a pipelined scan of the body memory,
// reporting apple/body/wall outcome, a sticky game-over flag and a saturating score.
module t09_collision_scan
  import t09_pkg::*;
#(
  parameter int unsigned GRID_W  = GridWDefault,
  parameter int unsigned GRID_H  = GridHDefault,
  parameter int unsigned MAX_LEN = 64,
  parameter int unsigned SCORE_W = 8,
  localparam int unsigned LEN_W  = $clog2(MAX_LEN + 1),
  localparam int unsigned IDX_W  = $clog2(MAX_LEN),
  localparam int unsigned X_W    = $clog2(GRID_W),
  localparam int unsigned Y_W    = $clog2(GRID_H)
) (
  input  logic               clk,
  input  logic               rst,
  input  logic               start,
  input  logic [X_W:0]       head_x,
  input  logic [Y_W:0]       head_y,
  input  logic [X_W-1:0]     apple_x,
  input  logic [Y_W-1:0]     apple_y,
  input  logic [LEN_W-1:0]   snake_len,
  input  logic               wrap_mode,
  t09_collision_scan_if.master body,
  output logic               busy,
  output logic               done,
  output logic               good_coll,
  output logic               bad_coll,
  output logic [IDX_W-1:0]   hit_idx,
  output logic               game_over,
  output logic [SCORE_W-1:0] apple_cnt
);

  state_e             state_q, state_d;
  logic [X_W:0]       hx_q, hx_d;
  logic [Y_W:0]       hy_q, hy_d;
  logic [X_W-1:0]     ax_q, ax_d;
  logic [Y_W-1:0]     ay_q, ay_d;
  logic [LEN_W-1:0]   len_q, len_d;
  logic               wrap_q, wrap_d;
  logic [LEN_W-1:0]   rd_cnt_q, rd_cnt_d;
  logic               cmp_valid_q, cmp_valid_d;
  logic [IDX_W-1:0]   cmp_idx_q, cmp_idx_d;
  logic               good_q, good_d;
  logic               bad_q, bad_d;
  logic [IDX_W-1:0]   hit_q, hit_d;
  logic               over_q, over_d;
  logic [SCORE_W-1:0] cnt_q, cnt_d;

  logic rd_go;
  logic wall_hit;
  logic apple_match;
  logic body_match;
  logic fin;
  logic fin_bad;

  // Head carries one extra bit, so an off-grid head can never equal an on-grid cell.
  assign wall_hit    = !wrap_q && ((32'(hx_q) >= GRID_W) || (32'(hy_q) >= GRID_H));
  assign apple_match = (hx_q == {1'b0, ax_q}) && (hy_q == {1'b0, ay_q});
  assign body_match  = (hx_q == {1'b0, body.body_x}) && (hy_q == {1'b0, body.body_y});
  assign rd_go       = (state_q == SCAN) && (rd_cnt_q < len_q);

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q     <= IDLE;
      hx_q        <= '0;
      hy_q        <= '0;
      ax_q        <= '0;
      ay_q        <= '0;
      len_q       <= '0;
      wrap_q      <= 1'b0;
      rd_cnt_q    <= '0;
      cmp_valid_q <= 1'b0;
      cmp_idx_q   <= '0;
      good_q      <= 1'b0;
      bad_q       <= 1'b0;
      hit_q       <= '0;
      over_q      <= 1'b0;
      cnt_q       <= '0;
    end else begin
      state_q     <= state_d;
      hx_q        <= hx_d;
      hy_q        <= hy_d;
      ax_q        <= ax_d;
      ay_q        <= ay_d;
      len_q       <= len_d;
      wrap_q      <= wrap_d;
      rd_cnt_q    <= rd_cnt_d;
      cmp_valid_q <= cmp_valid_d;
      cmp_idx_q   <= cmp_idx_d;
      good_q      <= good_d;
      bad_q       <= bad_d;
      hit_q       <= hit_d;
      over_q      <= over_d;
      cnt_q       <= cnt_d;
    end
  end

  always_comb begin
    state_d     = state_q;
    hx_d        = hx_q;
    hy_d        = hy_q;
    ax_d        = ax_q;
    ay_d        = ay_q;
    len_d       = len_q;
    wrap_d      = wrap_q;
    rd_cnt_d    = rd_cnt_q;
    cmp_valid_d = 1'b0;
    cmp_idx_d   = cmp_idx_q;
    good_d      = good_q;
    bad_d       = bad_q;
    hit_d       = hit_q;
    over_d      = over_q;
    cnt_d       = cnt_q;
    fin         = 1'b0;
    fin_bad     = 1'b0;

    unique case (state_q)
      IDLE: begin
        if (start && !over_q) begin
          state_d = CHECK;
          hx_d    = head_x;
          hy_d    = head_y;
          ax_d    = apple_x;
          ay_d    = apple_y;
          len_d   = snake_len;
          wrap_d  = wrap_mode;
          good_d  = 1'b0;
          bad_d   = 1'b0;
          hit_d   = '0;
        end
      end
      CHECK: begin
        rd_cnt_d = '0;
        if (wall_hit || (len_q == '0)) begin
          state_d = FINISH;
          fin     = 1'b1;
          fin_bad = wall_hit;
        end else begin
          state_d = SCAN;
        end
      end
      SCAN: begin
        // Read for index n is issued while the data of index n-1 is being compared.
        if (rd_go) rd_cnt_d = rd_cnt_q + LEN_W'(1);
        cmp_valid_d = rd_go;
        cmp_idx_d   = rd_cnt_q[IDX_W-1:0];
        if (cmp_valid_q && body_match) begin
          state_d = FINISH;
          fin     = 1'b1;
          fin_bad = 1'b1;
          hit_d   = cmp_idx_q;
        end else if (cmp_valid_q && (rd_cnt_q == len_q)) begin
          state_d = FINISH;
          fin     = 1'b1;
        end
      end
      FINISH: begin
        state_d = IDLE;
      end
      default: begin
        state_d = IDLE;
      end
    endcase

    if (fin) begin
      bad_d  = fin_bad;
      good_d = !fin_bad && apple_match;
      over_d = over_q | fin_bad;
      if (good_d && (cnt_q != '1)) cnt_d = cnt_q + SCORE_W'(1);
    end
  end

  always_comb begin
    busy             = (state_q != IDLE);
    done             = (state_q == FINISH);
    body.body_rd_en  = rd_go;
    body.body_rd_idx = rd_go ? rd_cnt_q[IDX_W-1:0] : '0;
  end

  assign good_coll = good_q;
  assign bad_coll  = bad_q;
  assign hit_idx   = hit_q;
  assign game_over = over_q;
  assign apple_cnt = cnt_q;

endmodule

// File: tb/tb_t09_collision_scan.sv
// Bench for t09_collision_scan: fixed vectors, hand-written reset/start corner cases,
// and randomized transactions against a behavioural outcome model.
module tb_t09_collision_scan;

  localparam int GW = 32;
  localparam int GH = 24;

  logic       clk = 1'b0;
  logic       rst;
  logic       start;
  logic [5:0] head_x, head_y;
  logic [4:0] apple_x, apple_y;
  logic [6:0] snake_len;
  logic       wrap_mode;

  logic       busy, done, good_coll, bad_coll, game_over;
  logic [5:0] hit_idx;
  logic [7:0] apple_cnt;
  logic       busy2, done2, good2, bad2, over2;
  logic [5:0] hit2;
  logic [1:0] apple_cnt2;

  t09_collision_scan_if #(.IDX_W(6), .X_W(5), .Y_W(5)) bif ();
  t09_collision_scan_if #(.IDX_W(6), .X_W(5), .Y_W(5)) bif2 ();

  t09_collision_scan #(.SCORE_W(8)) dut (
    .clk(clk), .rst(rst), .start(start), .head_x(head_x), .head_y(head_y),
    .apple_x(apple_x), .apple_y(apple_y), .snake_len(snake_len), .wrap_mode(wrap_mode),
    .body(bif), .busy(busy), .done(done), .good_coll(good_coll), .bad_coll(bad_coll),
    .hit_idx(hit_idx), .game_over(game_over), .apple_cnt(apple_cnt)
  );

  t09_collision_scan #(.SCORE_W(2)) dut2 (
    .clk(clk), .rst(rst), .start(start), .head_x(head_x), .head_y(head_y),
    .apple_x(apple_x), .apple_y(apple_y), .snake_len(snake_len), .wrap_mode(wrap_mode),
    .body(bif2), .busy(busy2), .done(done2), .good_coll(good2), .bad_coll(bad2),
    .hit_idx(hit2), .game_over(over2), .apple_cnt(apple_cnt2)
  );

  always #5 clk = ~clk;

  logic [4:0] mem_x [64];
  logic [4:0] mem_y [64];

  always @(posedge clk) begin
    if (bif.body_rd_en) begin
      bif.body_x <= mem_x[bif.body_rd_idx];
      bif.body_y <= mem_y[bif.body_rd_idx];
    end
    if (bif2.body_rd_en) begin
      bif2.body_x <= mem_x[bif2.body_rd_idx];
      bif2.body_y <= mem_y[bif2.body_rd_idx];
    end
  end

  int total = 0;
  int bad = 0;
  int m_cnt, m_cnt2;
  bit m_over;

  task automatic check(input string nm, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %0d expected %0d", nm, act, exp);
    end
  endtask

  task automatic do_reset();
    @(negedge clk);
    rst = 1'b1;
    start = 1'b0;
    @(negedge clk);
    rst = 1'b0;
    m_cnt = 0;
    m_cnt2 = 0;
    m_over = 1'b0;
  endtask

  task automatic fill_mem(input int fx, input int fy);
    for (int i = 0; i < 64; i++) begin
      mem_x[i] = 5'(fx);
      mem_y[i] = 5'(fy);
    end
  endtask

  // Outcome from the game rules: wall first, then the first body segment equal to the head.
  task automatic model(input int hx, input int hy, input int ax, input int ay, input int len,
                       input bit wrap, output int edone, output int ebad, output int egood,
                       output int ehit, output int ereads);
    int j;
    bit apple;
    apple = (hx == ax) && (hy == ay);
    ehit = 0;
    if (!wrap && (hx >= GW || hy >= GH)) begin
      edone = 2; ebad = 1; egood = 0; ereads = 0;
      return;
    end
    j = -1;
    for (int i = 0; i < len; i++)
      if (j < 0 && int'(mem_x[i]) == hx && int'(mem_y[i]) == hy) j = i;
    if (len == 0) begin
      edone = 2; ebad = 0; egood = int'(apple); ereads = 0;
    end else if (j >= 0) begin
      edone = j + 4; ebad = 1; egood = 0; ehit = j;
      ereads = (j + 2 < len) ? j + 2 : len;
    end else begin
      edone = len + 3; ebad = 0; egood = int'(apple); ereads = len;
    end
  endtask

  // Issues one start, then scrambles the inputs so only latched values can matter.
  task automatic txn(input int hx, input int hy, input int ax, input int ay, input int len,
                     input bit wrap, input int poke, output int dcyc, output int nrd,
                     output bit seq_ok);
    dcyc = -1;
    nrd = 0;
    seq_ok = 1'b1;
    @(negedge clk);
    head_x = 6'(hx); head_y = 6'(hy); apple_x = 5'(ax); apple_y = 5'(ay);
    snake_len = 7'(len); wrap_mode = wrap; start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    head_x = 6'd32; head_y = 6'd0; apple_x = 5'd31; apple_y = 5'd23;
    snake_len = 7'd0; wrap_mode = 1'b0;
    for (int k = 1; k <= 120; k++) begin
      if (bif.body_rd_en) begin
        if (int'(bif.body_rd_idx) != nrd || k != nrd + 2) seq_ok = 1'b0;
        nrd++;
      end
      if (done) begin
        dcyc = k;
        break;
      end
      @(negedge clk);
      start = (k + 1 == poke);
    end
    start = 1'b0;
  endtask

  task automatic check_txn(input string nm, input int hx, input int hy, input int ax,
                           input int ay, input int len, input bit wrap, input int poke);
    int edone, ebad, egood, ehit, ereads, dcyc, nrd;
    bit seq_ok;
    model(hx, hy, ax, ay, len, wrap, edone, ebad, egood, ehit, ereads);
    if (ebad != 0) m_over = 1'b1;
    if (egood != 0) begin
      if (m_cnt < 255) m_cnt++;
      if (m_cnt2 < 3) m_cnt2++;
    end
    txn(hx, hy, ax, ay, len, wrap, poke, dcyc, nrd, seq_ok);
    check({nm, ".done_cycle"}, dcyc, edone);
    check({nm, ".reads"}, nrd, ereads);
    check({nm, ".read_seq"}, 32'(seq_ok), 1);
    check({nm, ".bad"}, 32'(bad_coll), ebad);
    check({nm, ".good"}, 32'(good_coll), egood);
    check({nm, ".hit_idx"}, 32'(hit_idx), ehit);
    check({nm, ".game_over"}, 32'(game_over), 32'(m_over));
    check({nm, ".apple_cnt"}, 32'(apple_cnt), m_cnt);
    check({nm, ".apple_cnt_w2"}, 32'(apple_cnt2), m_cnt2);
    check({nm, ".dut2_flags"}, {bad2, good2, over2, done2}, {bad_coll, good_coll, game_over, 1'b1});
    @(negedge clk);
    check({nm, ".done_pulse"}, {busy, done}, 0);
    check({nm, ".hold"}, {bad_coll, good_coll, hit_idx}, {1'(ebad), 1'(egood), 6'(ehit)});
  endtask

  typedef struct {
    int hx, hy, ax, ay, len;
    bit wrap;
    int seg;
    int edone, ebad, egood, ehit, ereads;
  } vec_t;

  vec_t vt[11];

  initial begin
    int dcyc, nrd, seen, hx, hy, ax, ay, len;
    bit seq_ok;
    rst = 1'b1; start = 1'b0; head_x = '0; head_y = '0; apple_x = '0; apple_y = '0;
    snake_len = '0; wrap_mode = 1'b0;
    fill_mem(31, 23);
    repeat (2) @(negedge clk);
    check("reset_outputs", {busy, done, good_coll, bad_coll, hit_idx, game_over, apple_cnt,
                            bif.body_rd_en}, 0);
    rst = 1'b0;

    //          hx  hy  ax  ay len wrap seg done bad good hit reads
    vt[0]  = '{32,  5,  0,  0,  3, 1'b0, -1,  2, 1, 0, 0,  0};
    vt[1]  = '{10, 10, 10, 10,  5, 1'b0, -1,  8, 0, 1, 0,  5};
    vt[2]  = '{ 7,  9,  7,  9,  5, 1'b0,  2,  6, 1, 0, 2,  4};
    vt[3]  = '{40, 30,  0,  0,  0, 1'b1, -1,  2, 0, 0, 0,  0};
    vt[4]  = '{ 5, 24,  5,  0,  4, 1'b0, -1,  2, 1, 0, 0,  0};
    vt[5]  = '{32,  5,  0,  0,  2, 1'b1, -1,  5, 0, 0, 0,  2};
    vt[6]  = '{ 3,  4,  0,  0,  1, 1'b0,  0,  4, 1, 0, 0,  1};
    vt[7]  = '{ 1,  2,  1,  2,  6, 1'b0,  5,  9, 1, 0, 5,  6};
    vt[8]  = '{ 4,  4,  4,  4,  0, 1'b0, -1,  2, 0, 1, 0,  0};
    vt[9]  = '{ 0,  0,  1,  0, 64, 1'b0, -1, 67, 0, 0, 0, 64};
    vt[10] = '{31, 23,  0,  0,  3, 1'b0, -1,  4, 1, 0, 0,  2};

    foreach (vt[v]) begin
      do_reset();
      fill_mem(31, 23);
      if (vt[v].seg >= 0) begin
        mem_x[vt[v].seg] = 5'(vt[v].hx);
        mem_y[vt[v].seg] = 5'(vt[v].hy);
      end
      txn(vt[v].hx, vt[v].hy, vt[v].ax, vt[v].ay, vt[v].len, vt[v].wrap, 0, dcyc, nrd, seq_ok);
      check($sformatf("vec%0d.done_cycle", v), dcyc, vt[v].edone);
      check($sformatf("vec%0d.reads", v), nrd, vt[v].ereads);
      check($sformatf("vec%0d.read_seq", v), 32'(seq_ok), 1);
      check($sformatf("vec%0d.flags", v), {bad_coll, good_coll, game_over},
            {1'(vt[v].ebad), 1'(vt[v].egood), 1'(vt[v].ebad)});
      check($sformatf("vec%0d.hit_idx", v), 32'(hit_idx), vt[v].ehit);
      check($sformatf("vec%0d.apple_cnt", v), 32'(apple_cnt), vt[v].egood);
    end

    // Second start while busy must be ignored; inputs scrambled after accept.
    do_reset();
    fill_mem(31, 23);
    check_txn("busy_start", 2, 3, 2, 3, 10, 1'b0, 3);

    // Start after game over is ignored.
    check_txn("make_over", 33, 1, 0, 0, 2, 1'b0, 0);
    @(negedge clk);
    head_x = 6'd2; head_y = 6'd3; snake_len = 7'd2; start = 1'b1;
    seen = 0;
    for (int k = 0; k < 6; k++) begin
      @(negedge clk);
      start = 1'b0;
      if (busy || done) seen++;
    end
    check("over_blocks_start", seen, 0);

    // Reset mid-scan abandons the check with no done pulse.
    do_reset();
    check_txn("pre_rst_apple", 6, 6, 6, 6, 0, 1'b0, 0);
    @(negedge clk);
    head_x = 6'd2; head_y = 6'd3; apple_x = 5'd2; apple_y = 5'd3;
    snake_len = 7'd10; wrap_mode = 1'b0; start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    repeat (3) @(negedge clk);
    check("pre_rst_scanning", {busy, bif.body_rd_en}, 2'b11);
    rst = 1'b1;
    @(negedge clk);
    check("rst_mid_scan", {busy, done, good_coll, bad_coll, hit_idx, game_over, apple_cnt,
                           bif.body_rd_en}, 0);
    rst = 1'b0;
    seen = 0;
    for (int k = 0; k < 15; k++) begin
      @(negedge clk);
      if (done || busy) seen++;
    end
    check("rst_no_done", seen, 0);

    // Reset wins over a simultaneous start.
    @(negedge clk);
    rst = 1'b1; start = 1'b1; snake_len = 7'd3;
    @(negedge clk);
    rst = 1'b0; start = 1'b0;
    check("rst_beats_start", 32'(busy), 0);
    m_cnt = 0; m_cnt2 = 0; m_over = 1'b0;

    // Narrow score saturates at 3.
    do_reset();
    fill_mem(31, 23);
    for (int n = 0; n < 4; n++) begin
      check_txn($sformatf("apple%0d", n), n, n, n, n, n, 1'b0, 0);
      check($sformatf("score_w2_seq%0d", n), 32'(apple_cnt2), (n < 3) ? n + 1 : 3);
    end

    // Randomized transactions against the outcome model.
    do_reset();
    for (int t = 0; t < 40; t++) begin
      if (m_over) do_reset();
      len = ($urandom_range(0, 9) == 0) ? 64 : int'($urandom_range(0, 12));
      for (int i = 0; i < 64; i++) begin
        mem_x[i] = 5'($urandom_range(0, 7));
        mem_y[i] = 5'($urandom_range(0, 7));
      end
      if ($urandom_range(0, 3) == 0) begin
        hx = $urandom_range(0, 63);
        hy = $urandom_range(0, 31);
      end else begin
        hx = $urandom_range(0, 9);
        hy = $urandom_range(0, 9);
      end
      if ($urandom_range(0, 1) == 1 && hx < 32 && hy < 32) begin
        ax = hx; ay = hy;
      end else begin
        ax = $urandom_range(0, 31); ay = $urandom_range(0, 23);
      end
      check_txn($sformatf("rand%0d", t), hx, hy, ax, ay, len, 1'($urandom_range(0, 1)), 0);
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
